// File: rtl/exec_pkg.sv
// Shared opcodes, flag positions, PSR masks and the instruction decoder for exec_stage.
package exec_pkg;

  localparam logic [3:0] OP_REG     = 4'h0;
  localparam logic [3:0] OP_REG_EXT = 4'h8;
  localparam logic [3:0] OP_ANDI    = 4'h1;
  localparam logic [3:0] OP_ORI     = 4'h2;
  localparam logic [3:0] OP_XORI    = 4'h3;
  localparam logic [3:0] EXT_IMM    = 4'hF;

  localparam logic [7:0] ALU_AND   = 8'h01;
  localparam logic [7:0] ALU_OR    = 8'h02;
  localparam logic [7:0] ALU_XOR   = 8'h03;
  localparam logic [7:0] ALU_ADD   = 8'h05;
  localparam logic [7:0] ALU_ADDU  = 8'h06;
  localparam logic [7:0] ALU_SUB   = 8'h09;
  localparam logic [7:0] ALU_CMP   = 8'h0B;
  localparam logic [7:0] ALU_MOV   = 8'h0D;
  localparam logic [7:0] ALU_MUL   = 8'h0E;
  localparam logic [7:0] ALU_LSH   = 8'h84;
  localparam logic [7:0] ALU_ANDI  = 8'h1F;
  localparam logic [7:0] ALU_ORI   = 8'h2F;
  localparam logic [7:0] ALU_XORI  = 8'h3F;
  localparam logic [7:0] ALU_ADDI  = 8'h5F;
  localparam logic [7:0] ALU_ADDUI = 8'h6F;
  localparam logic [7:0] ALU_SUBI  = 8'h9F;
  localparam logic [7:0] ALU_CMPI  = 8'hBF;
  localparam logic [7:0] ALU_MOVI  = 8'hDF;
  localparam logic [7:0] ALU_MULI  = 8'hEF;

  localparam int FLAG_C = 4;
  localparam int FLAG_L = 3;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  // Bit order is {C, L, F, Z, N}.
  localparam logic [4:0] MASK_NONE  = 5'b00000;
  localparam logic [4:0] MASK_ARITH = 5'b10100;
  localparam logic [4:0] MASK_CMP   = 5'b01011;

  typedef struct packed {
    logic       is_imm;
    logic       zext;
    logic       wb;
    logic       mov;
    logic [4:0] psr_mask;
  } ctrl_t;

  function automatic logic [7:0] alu_opcode(input logic [15:0] instr);
    logic is_reg;
    is_reg = (instr[15:12] == OP_REG) || (instr[15:12] == OP_REG_EXT);
    return is_reg ? instr[15:8] & 8'hF0 | {4'h0, instr[7:4]} : {instr[15:12], EXT_IMM};
  endfunction

  function automatic ctrl_t decode(input logic [15:0] instr);
    ctrl_t c;
    c          = '0;
    c.is_imm   = !((instr[15:12] == OP_REG) || (instr[15:12] == OP_REG_EXT));
    c.zext     = (instr[15:12] == OP_ANDI) || (instr[15:12] == OP_ORI) || (instr[15:12] == OP_XORI);
    case (alu_opcode(instr))
      ALU_AND, ALU_OR, ALU_XOR, ALU_MUL, ALU_LSH,
      ALU_ANDI, ALU_ORI, ALU_XORI, ALU_MULI:       c.wb = 1'b1;
      ALU_ADD, ALU_ADDU, ALU_SUB,
      ALU_ADDI, ALU_ADDUI, ALU_SUBI: begin
        c.wb       = 1'b1;
        c.psr_mask = MASK_ARITH;
      end
      ALU_CMP, ALU_CMPI:                           c.psr_mask = MASK_CMP;
      ALU_MOV, ALU_MOVI: begin
        c.wb  = 1'b1;
        c.mov = 1'b1;
      end
      default:                                     c.psr_mask = MASK_NONE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/exec_regfile.sv
// 16x16 register file: two operand read ports, a debug read port, one synchronous write port.
module exec_regfile #(
  parameter int NREGS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  i_raddr_a,
  output logic [15:0] o_rdata_a,
  input  logic [3:0]  i_raddr_b,
  output logic [15:0] o_rdata_b,
  input  logic [3:0]  i_raddr_dbg,
  output logic [15:0] o_rdata_dbg,
  input  logic        i_we,
  input  logic [3:0]  i_waddr,
  input  logic [15:0] i_wdata
);

  logic [15:0] r_regs [NREGS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (i_we) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  // Reads see the pre-write value; a same-cycle write lands at the edge.
  assign o_rdata_a   = r_regs[i_raddr_a];
  assign o_rdata_b   = r_regs[i_raddr_b];
  assign o_rdata_dbg = r_regs[i_raddr_dbg];

endmodule

// File: rtl/exec_stage.sv
// Decode/operand-fetch (D) and ALU/writeback (X) stages around an external 16-bit ALU.
// Define EXEC_STAGE_FWD_EN to forward X writeback into D operands instead of inserting a bubble.
module exec_stage import exec_pkg::*; #(
  parameter int         NREGS     = 16,
  parameter logic [4:0] RESET_PSR = 5'b00000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  output logic        instr_ready,
  input  logic        stall,
  output logic [15:0] alu_rdest,
  output logic [15:0] alu_rsrc,
  output logic [7:0]  alu_op,
  input  logic [15:0] alu_result,
  input  logic [4:0]  alu_flags,
  output logic [4:0]  psr,
  output logic        wb_en,
  output logic [3:0]  wb_addr,
  output logic [15:0] wb_data,
  input  logic [3:0]  dbg_raddr,
  output logic [15:0] dbg_rdata
);

  logic        r_x_valid;
  logic [15:0] r_alu_rdest;
  logic [15:0] r_alu_rsrc;
  logic [7:0]  r_alu_op;
  logic [3:0]  r_x_addr;
  logic        r_x_wb;
  logic        r_x_mov;
  logic [4:0]  r_x_mask;
  logic [4:0]  r_psr;

  logic [3:0]  w_rdest_a;
  logic [3:0]  w_rsrc_a;
  ctrl_t       w_ctrl;
  logic [15:0] w_rf_rdest;
  logic [15:0] w_rf_rsrc;
  logic [15:0] w_imm;
  logic [15:0] w_opnd_rdest;
  logic [15:0] w_opnd_rsrc;
  logic        w_fwd_rdest;
  logic        w_fwd_rsrc;
  logic        w_hazard;
  logic        w_accept;
  logic        w_wb_en;
  logic [15:0] w_wb_data;

  assign w_rdest_a = instr[11:8];
  assign w_rsrc_a  = instr[3:0];
  assign w_ctrl    = decode(instr);

  exec_regfile #(.NREGS(NREGS)) u_regfile (
    .clk         (clk),
    .reset       (reset),
    .i_raddr_a   (w_rdest_a),
    .o_rdata_a   (w_rf_rdest),
    .i_raddr_b   (w_rsrc_a),
    .o_rdata_b   (w_rf_rsrc),
    .i_raddr_dbg (dbg_raddr),
    .o_rdata_dbg (dbg_rdata),
    .i_we        (w_wb_en),
    .i_waddr     (r_x_addr),
    .i_wdata     (w_wb_data)
  );

  assign w_wb_en   = r_x_valid && !stall && r_x_wb;
  assign w_wb_data = r_x_mov ? r_alu_rsrc : alu_result;

`ifdef EXEC_STAGE_FWD_EN
  assign w_fwd_rdest = w_wb_en && (r_x_addr == w_rdest_a);
  assign w_fwd_rsrc  = w_wb_en && (r_x_addr == w_rsrc_a);
  assign w_hazard    = 1'b0;
`else
  assign w_fwd_rdest = 1'b0;
  assign w_fwd_rsrc  = 1'b0;
  assign w_hazard    = w_wb_en &&
                       ((r_x_addr == w_rdest_a) || (!w_ctrl.is_imm && (r_x_addr == w_rsrc_a)));
`endif

  assign w_imm        = w_ctrl.zext ? {8'h00, instr[7:0]} : {{8{instr[7]}}, instr[7:0]};
  assign w_opnd_rdest = w_fwd_rdest ? w_wb_data : w_rf_rdest;
  assign w_opnd_rsrc  = w_ctrl.is_imm ? w_imm : (w_fwd_rsrc ? w_wb_data : w_rf_rsrc);

  assign instr_ready = !stall && !reset && !w_hazard;
  assign w_accept    = instr_valid && instr_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x_valid   <= 1'b0;
      r_alu_rdest <= '0;
      r_alu_rsrc  <= '0;
      r_alu_op    <= '0;
      r_x_addr    <= '0;
      r_x_wb      <= 1'b0;
      r_x_mov     <= 1'b0;
      r_x_mask    <= '0;
      r_psr       <= RESET_PSR;
    end else if (!stall) begin
      // NOPs carry an all-zero mask, so the PSR update needs no class check here.
      if (r_x_valid) r_psr <= (r_psr & ~r_x_mask) | (alu_flags & r_x_mask);
      r_x_valid <= w_accept;
      if (w_accept) begin
        r_alu_rdest <= w_opnd_rdest;
        r_alu_rsrc  <= w_opnd_rsrc;
        r_alu_op    <= alu_opcode(instr);
        r_x_addr    <= w_rdest_a;
        r_x_wb      <= w_ctrl.wb;
        r_x_mov     <= w_ctrl.mov;
        r_x_mask    <= w_ctrl.psr_mask;
      end
    end
  end

  assign alu_rdest = r_alu_rdest;
  assign alu_rsrc  = r_alu_rsrc;
  assign alu_op    = r_alu_op;
  assign psr       = r_psr;
  assign wb_en     = w_wb_en;
  assign wb_addr   = r_x_addr;
  assign wb_data   = w_wb_data;

endmodule

// File: tb/tb_exec_stage.sv
// Directed bench for exec_stage: writebacks are scoreboarded, state is read back via the debug port.
module tb_exec_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic        stall;
  logic [15:0] alu_rdest;
  logic [15:0] alu_rsrc;
  logic [7:0]  alu_op;
  logic [15:0] alu_result;
  logic [4:0]  alu_flags;
  logic [4:0]  psr;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;
  logic [3:0]  dbg_raddr;
  logic [15:0] dbg_rdata;

  int checks = 0;
  int errors = 0;
  logic [19:0] exp_q[$];
  logic [19:0] mon_e;

  always #5 clk = ~clk;

  exec_stage dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .stall       (stall),
    .alu_rdest   (alu_rdest),
    .alu_rsrc    (alu_rsrc),
    .alu_op      (alu_op),
    .alu_result  (alu_result),
    .alu_flags   (alu_flags),
    .psr         (psr),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .dbg_raddr   (dbg_raddr),
    .dbg_rdata   (dbg_rdata)
  );

  // Behavioural ALU: flags {C,L,F,Z,N}; L/Z/N always compare Rdest against Rsrc.
  always_comb begin
    logic [16:0] s;
    logic [15:0] a, b, r, nb;
    logic        c, f;
    a = alu_rdest; b = alu_rsrc; r = 16'h0; c = 1'b0; f = 1'b0; s = 17'h0; nb = -alu_rsrc;
    case (alu_op)
      8'h01, 8'h1F: r = a & b;
      8'h02, 8'h2F: r = a | b;
      8'h03, 8'h3F: r = a ^ b;
      8'h05, 8'h5F, 8'h06, 8'h6F: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[15:0];
        c = s[16];
        f = (a[15] == b[15]) && (r[15] != a[15]);
      end
      8'h09, 8'h9F, 8'h0B, 8'hBF: begin
        r = a - b;
        c = a < b;
        f = (a[15] != b[15]) && (r[15] != a[15]);
      end
      8'h0D, 8'hDF: r = b;
      8'h0E, 8'hEF: r = a * b;
      8'h84:        r = b[15] ? (a >> nb[3:0]) : (a << b[3:0]);
      default:      r = 16'h0;
    endcase
    alu_result = r;
    alu_flags  = {c, (a < b), f, (a == b), ($signed(a) < $signed(b))};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Monitor: every writeback must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && wb_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_wb: got r%0d=%h expected no writeback", wb_addr, wb_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wb_addr", {28'h0, wb_addr}, {28'h0, mon_e[19:16]});
        chk("wb_data", {16'h0, wb_data}, {16'h0, mon_e[15:0]});
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    @(negedge clk);
  endtask

  // Call aligned just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [15:0] ins, input logic exp_wb, input logic [3:0] a,
                      input logic [15:0] d, output int waits);
    waits       = 0;
    instr_valid = 1'b1;
    instr       = ins;
    if (exp_wb) exp_q.push_back({a, d});
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (instr_ready) break;
      waits++;
    end
    if (!instr_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got ready=0 expected ready=1 for instr %h", ins);
    end
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
  endtask

  task automatic dbg(input string name, input logic [3:0] addr, input logic [15:0] exp);
    dbg_raddr = addr;
    #1;
    chk(name, {16'h0, dbg_rdata}, {16'h0, exp});
  endtask

  initial begin
    int w;
    reset = 1'b1; instr_valid = 1'b0; instr = 16'h0; stall = 1'b0; dbg_raddr = 4'h0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'h0, instr_ready}, 0);
    chk("rst_psr", {27'h0, psr}, 0);
    chk("rst_wb_en", {31'h0, wb_en}, 0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_alu_op", {24'h0, alu_op}, 0);
    chk("rst_alu_rdest", {16'h0, alu_rdest}, 0);
    chk("rst_alu_rsrc", {16'h0, alu_rsrc}, 0);
    chk("idle_ready", {31'h0, instr_ready}, 1);

    // MOVI r1,#0x7F ; MOVI r2,#-1
    sync();
    send(16'hD17F, 1'b1, 4'd1, 16'h007F, w);
    @(negedge clk);
    chk("movi_op", {24'h0, alu_op}, 32'hDF);
    chk("movi_imm", {16'h0, alu_rsrc}, 32'h007F);
    sync();
    send(16'hD2FF, 1'b1, 4'd2, 16'hFFFF, w);
    settle();
    dbg("r1_movi", 4'd1, 16'h007F);
    dbg("r2_movi", 4'd2, 16'hFFFF);
    chk("psr_movi", {27'h0, psr}, 0);

    // r1 = 0xFFFF >> 1 = 0x7FFF, then ADD r1,r1 overflows: F set, Z from ALU masked off
    sync();
    send(16'hD1FF, 1'b1, 4'd1, 16'hFFFF, w);
    send(16'h8142, 1'b1, 4'd1, 16'h7FFF, w);
    send(16'h0151, 1'b1, 4'd1, 16'hFFFE, w);
    settle();
    dbg("r1_add", 4'd1, 16'hFFFE);
    chk("psr_add", {27'h0, psr}, 32'b00100);

    // CMP r3,r4 with both 5: Z set, no writeback
    sync();
    send(16'hD305, 1'b1, 4'd3, 16'h0005, w);
    send(16'hD405, 1'b1, 4'd4, 16'h0005, w);
    settle();
    sync();
    send(16'h03B4, 1'b0, 4'd0, 16'h0000, w);
    @(negedge clk);
    chk("cmp_wb_en", {31'h0, wb_en}, 0);
    settle();
    chk("psr_cmp", {27'h0, psr}, 32'b00110);
    dbg("r3_cmp", 4'd3, 16'h0005);

    // ANDI r3,#0xF0: zero-extended operand, PSR untouched
    sync();
    send(16'h13F0, 1'b1, 4'd3, 16'h0000, w);
    @(negedge clk);
    chk("andi_op", {24'h0, alu_op}, 32'h1F);
    chk("andi_imm", {16'h0, alu_rsrc}, 32'h00F0);
    settle();
    chk("psr_andi", {27'h0, psr}, 32'b00110);
    dbg("r3_andi", 4'd3, 16'h0000);

    // RAW: MOVI r5,#3 ; ADD r5,r5 offered back to back
    sync();
    send(16'hD503, 1'b1, 4'd5, 16'h0003, w);
    send(16'h0555, 1'b1, 4'd5, 16'h0006, w);
`ifdef EXEC_STAGE_FWD_EN
    chk("raw_ready_drops", w, 0);
`else
    chk("raw_ready_drops", w, 1);
`endif
    settle();
    dbg("r5_raw", 4'd5, 16'h0006);
    chk("psr_raw", {27'h0, psr}, 32'b00010);

    // ADD r6,r5 held in X by a 3-cycle stall, writes back on release
    sync();
    send(16'h0655, 1'b1, 4'd6, 16'h0006, w);
    stall = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stall_wb_en", {31'h0, wb_en}, 0);
      chk("stall_op", {24'h0, alu_op}, 32'h05);
      chk("stall_rdest", {16'h0, alu_rdest}, 0);
      chk("stall_rsrc", {16'h0, alu_rsrc}, 32'h0006);
      chk("stall_ready", {31'h0, instr_ready}, 0);
    end
    @(posedge clk); #1 stall = 1'b0;
    @(negedge clk);
    chk("release_wb_en", {31'h0, wb_en}, 1);
    settle();
    dbg("r6_stall", 4'd6, 16'h0006);
    chk("psr_stall", {27'h0, psr}, 32'b00010);

    // Asynchronous reset mid-cycle with MOVI r7 in X: discarded, everything cleared
    sync();
    send(16'hD712, 1'b0, 4'd0, 16'h0000, w);
    #2 reset = 1'b1;
    @(negedge clk);
    chk("arst_wb_en", {31'h0, wb_en}, 0);
    chk("arst_psr", {27'h0, psr}, 0);
    chk("arst_alu_op", {24'h0, alu_op}, 0);
    for (int i = 0; i < 16; i++) dbg("arst_reg", i[3:0], 16'h0000);
    @(posedge clk); #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
